// File: rtl/ctrl_word_pipe.sv
// rtl/ctrl_word_pipe.sv - elastic control-word pipeline with flush, bubble collapse and hazard match
module ctrl_word_pipe #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_payload,
  input  logic [4:0]                 in_rd,
  input  logic                       in_regwrite,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_payload,
  output logic [4:0]                 out_rd,
  output logic                       out_regwrite,
  input  logic [DEPTH-1:0]           flush_mask,
  input  logic [4:0]                 q_rs1,
  input  logic [4:0]                 q_rs2,
  output logic [DEPTH-1:0]           match_rs1,
  output logic [DEPTH-1:0]           match_rs2,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] payload_q [DEPTH];
  logic [WIDTH-1:0] payload_d [DEPTH];
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];
  logic [DEPTH-1:0] regwrite_q, regwrite_d;
  logic [OW-1:0]    occupancy_q, occupancy_d;
  logic [DEPTH-1:0] adv;
  logic             accept;

  // A stage only stalls when it sits in an unbroken run of valid stages
  // reaching the head while the consumer is not ready.
  always_comb begin
    logic full_run;
    adv      = '0;
    full_run = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      full_run = full_run & valid_q[k];
      adv[k]   = valid_q[k] & (out_ready | ~full_run);
    end
  end

  assign in_ready = ~valid_q[0] | adv[0];
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d       = '0;
    regwrite_d    = regwrite_q;
    payload_d     = payload_q;
    rd_d          = rd_q;
    valid_d[0]    = (accept | (valid_q[0] & ~adv[0])) & ~flush_mask[0];
    if (accept) begin
      payload_d[0]  = in_payload;
      rd_d[0]       = in_rd;
      regwrite_d[0] = in_regwrite;
    end
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = (adv[k-1] | (valid_q[k] & ~adv[k])) & ~flush_mask[k];
      if (adv[k-1]) begin
        payload_d[k]  = payload_q[k-1];
        rd_d[k]       = rd_q[k-1];
        regwrite_d[k] = regwrite_q[k-1];
      end
    end
  end

  always_comb begin
    occupancy_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy_d = occupancy_d + OW'(valid_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      occupancy_q <= '0;
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
    end
    regwrite_q <= regwrite_d;
    for (int k = 0; k < DEPTH; k++) begin
      payload_q[k] <= payload_d[k];
      rd_q[k]      <= rd_d[k];
    end
  end

  // Matches use pre-edge state, so a stage being flushed this cycle still reports.
  always_comb begin
    match_rs1 = '0;
    match_rs2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_rs1[k] = valid_q[k] & regwrite_q[k] & (rd_q[k] == q_rs1) & (q_rs1 != 5'd0);
      match_rs2[k] = valid_q[k] & regwrite_q[k] & (rd_q[k] == q_rs2) & (q_rs2 != 5'd0);
    end
  end

  assign out_valid    = valid_q[DEPTH-1];
  assign out_payload  = payload_q[DEPTH-1];
  assign out_rd       = rd_q[DEPTH-1];
  assign out_regwrite = regwrite_q[DEPTH-1];
  assign occupancy    = occupancy_q;

endmodule

// File: tb/tb_ctrl_word_pipe.sv
// tb/tb_ctrl_word_pipe.sv - randomized self-checking bench for ctrl_word_pipe
module tb_ctrl_word_pipe;

  localparam int D = 3;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_payload = '0;
  logic [4:0]    in_rd = '0;
  logic          in_regwrite = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_payload;
  logic [4:0]    out_rd;
  logic          out_regwrite;
  logic [D-1:0]  flush_mask = '0;
  logic [4:0]    q_rs1 = '0;
  logic [4:0]    q_rs2 = '0;
  logic [D-1:0]  match_rs1;
  logic [D-1:0]  match_rs2;
  logic [$clog2(D+1)-1:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;
  bit known = 1'b0;

  // Reference: one slot per stage, index D-1 is the head.
  logic         m_v  [D];
  logic [W-1:0] m_p  [D];
  logic [4:0]   m_rd [D];
  logic         m_rw [D];

  ctrl_word_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rd(out_rd), .out_regwrite(out_regwrite),
    .flush_mask(flush_mask), .q_rs1(q_rs1), .q_rs2(q_rs2),
    .match_rs1(match_rs1), .match_rs2(match_rs2), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lowest index of the full run that ends at the head; D when nothing is pinned.
  function automatic int pinned_from(input logic ordy);
    int b = D;
    if (!ordy) begin
      for (int k = D - 1; k >= 0; k--) begin
        if (m_v[k]) b = k;
        else break;
      end
    end
    return b;
  endfunction

  task automatic step(input logic r, input logic iv, input logic [W-1:0] p,
                      input logic [4:0] rd, input logic rw, input logic ordy,
                      input logic [D-1:0] fl, input logic [4:0] r1, input logic [4:0] r2);
    logic         n_v  [D];
    logic [W-1:0] n_p  [D];
    logic [4:0]   n_rd [D];
    logic         n_rw [D];
    logic [D-1:0] e_m1, e_m2;
    int           b, cnt;
    @(negedge clk);
    rst = r; in_valid = iv; in_payload = p; in_rd = rd; in_regwrite = rw;
    out_ready = ordy; flush_mask = fl; q_rs1 = r1; q_rs2 = r2;
    #1;
    b = pinned_from(ordy);
    if (known) begin
      cnt = 0;
      e_m1 = '0; e_m2 = '0;
      for (int k = 0; k < D; k++) begin
        if (m_v[k]) cnt++;
        e_m1[k] = m_v[k] && m_rw[k] && m_rd[k] == r1 && r1 != 0;
        e_m2[k] = m_v[k] && m_rw[k] && m_rd[k] == r2 && r2 != 0;
      end
      check("in_ready", W'(in_ready), W'(b != 0));
      check("out_valid", W'(out_valid), W'(m_v[D-1]));
      if (m_v[D-1]) begin
        check("out_payload", out_payload, m_p[D-1]);
        check("out_rd", W'(out_rd), W'(m_rd[D-1]));
        check("out_regwrite", W'(out_regwrite), W'(m_rw[D-1]));
      end
      check("match_rs1", W'(match_rs1), W'(e_m1));
      check("match_rs2", W'(match_rs2), W'(e_m2));
      check("occupancy", W'(occupancy), W'(cnt));
    end
    @(posedge clk);
    for (int k = 0; k < D; k++) begin
      n_v[k] = 1'b0; n_p[k] = m_p[k]; n_rd[k] = m_rd[k]; n_rw[k] = m_rw[k];
    end
    if (!r) begin
      for (int k = 0; k < D; k++) begin
        if (m_v[k] && k >= b) begin
          n_v[k] = 1'b1; n_p[k] = m_p[k]; n_rd[k] = m_rd[k]; n_rw[k] = m_rw[k];
        end else if (m_v[k] && k < D - 1) begin
          n_v[k+1] = 1'b1; n_p[k+1] = m_p[k]; n_rd[k+1] = m_rd[k]; n_rw[k+1] = m_rw[k];
        end
      end
      if (iv && b != 0) begin
        n_v[0] = 1'b1; n_p[0] = p; n_rd[0] = rd; n_rw[0] = rw;
      end
      for (int k = 0; k < D; k++) if (fl[k]) n_v[k] = 1'b0;
    end else begin
      known = 1'b1;
    end
    for (int k = 0; k < D; k++) begin
      m_v[k] = n_v[k]; m_p[k] = n_p[k]; m_rd[k] = n_rd[k]; m_rw[k] = n_rw[k];
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, '0, 5'd0, 1'b0, ordy, '0, 5'd0, 5'd0);
  endtask

  task automatic push(input logic [W-1:0] p, input logic [4:0] rd, input logic rw,
                      input logic ordy, input logic [D-1:0] fl);
    step(1'b0, 1'b1, p, rd, rw, ordy, fl, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 5'd0, 1'b0, 1'b0, '0, 5'd0, 5'd0);
    step(1'b1, 1'b0, '0, 5'd0, 1'b0, 1'b0, '0, 5'd0, 5'd0);
  endtask

  initial begin
    for (int k = 0; k < D; k++) begin
      m_v[k] = 1'b0; m_p[k] = '0; m_rd[k] = '0; m_rw[k] = 1'b0;
    end

    do_reset();
    idle(1'b1);

    // Streaming at full rate.
    for (int i = 1; i <= 6; i++) push(W'(i), 5'(i), 1'b1, 1'b1, '0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Fill against a stalled consumer, then release for one cycle.
    for (int i = 0; i < 4; i++) push(W'(16 + i), 5'd3, 1'b0, 1'b0, '0);
    push(W'(32), 5'd4, 1'b1, 1'b1, '0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Bubble collapse behind a stalled head.
    do_reset();
    push(W'(64), 5'd1, 1'b0, 1'b0, '0);
    idle(1'b0);
    idle(1'b0);
    push(W'(65), 5'd2, 1'b0, 1'b0, '0);
    idle(1'b0);
    idle(1'b0);

    // Flush of stages 0-1 while stage 1 advances and a new entry is accepted.
    do_reset();
    push(W'(80), 5'd1, 1'b0, 1'b1, '0);
    push(W'(81), 5'd2, 1'b0, 1'b1, '0);
    push(W'(82), 5'd3, 1'b0, 1'b1, 3'b011);
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b0; #1;
    check("flush_occ", W'(occupancy), W'(1));
    check("flush_head", out_payload, W'(80));
    idle(1'b0);

    // Hazard match vectors.
    do_reset();
    push(W'(96), 5'd5, 1'b0, 1'b0, '0);
    push(W'(97), 5'd5, 1'b1, 1'b0, '0);
    idle(1'b0);
    @(negedge clk); q_rs1 = 5'd5; q_rs2 = 5'd0; #1;
    check("haz_rs1", W'(match_rs1), W'(3'b010));
    check("haz_rs2", W'(match_rs2), W'(3'b000));
    push(W'(98), 5'd0, 1'b1, 1'b0, '0);
    @(negedge clk); q_rs1 = 5'd0; q_rs2 = 5'd5; #1;
    check("haz_x0", W'(match_rs1), W'(3'b000));
    check("haz_rs2_b", W'(match_rs2), W'(3'b010));

    // Reset mid-stream with an entry offered.
    do_reset();
    for (int i = 0; i < 3; i++) push(W'(112 + i), 5'd7, 1'b1, 1'b1, '0);
    step(1'b1, 1'b1, W'(200), 5'd9, 1'b1, 1'b0, '0, 5'd0, 5'd0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_occ", W'(occupancy), W'(0));
    idle(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           {$urandom, $urandom},
           5'($urandom_range(0, 7)),
           1'($urandom),
           $urandom_range(0, 2) != 0,
           ($urandom_range(0, 9) == 0) ? D'($urandom_range(0, 7)) : '0,
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_word_pipe.md
Name: ctrl_word_pipe

Overview:
- Parametrised elastic pipeline carrying decoded control words (payload plus rd / Regwrite_en sideband) from decode through DEPTH back-end stages.
- Generalises fixed per-stage control-word registers: configurable width and depth, valid/ready backpressure with bubble collapsing, per-stage flush, and per-stage register-hazard match vectors for the forwarding/stall unit.

Parameters:
- WIDTH, 64, payload bits per entry (packed control word plus any operand data); must be >= 1.
- DEPTH, 3, number of pipeline stages; stage 0 is youngest, stage DEPTH-1 drives outputs; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream entry offered.
- in_ready  out  1  pipe accepts entry this cycle.
- in_payload  in  WIDTH  entry payload.
- in_rd  in  5  destination register of entry.
- in_regwrite  in  1  entry writes rd.
- out_valid  out  1  stage DEPTH-1 holds an entry.
- out_ready  in  1  downstream consumes entry.
- out_payload  out  WIDTH  stage DEPTH-1 payload.
- out_rd  out  5  stage DEPTH-1 rd.
- out_regwrite  out  1  stage DEPTH-1 Regwrite_en.
- flush_mask  in  DEPTH  bit k invalidates stage k.
- q_rs1  in  5  hazard query source register 1.
- q_rs2  in  5  hazard query source register 2.
- match_rs1  out  DEPTH  bit k: stage k produces q_rs1.
- match_rs2  out  DEPTH  bit k: stage k produces q_rs2.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages (registered).

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: all stage valid bits 0, occupancy 0. Payload/rd/regwrite registers need not reset.
- Advance rule, evaluated combinationally from current state:
  - adv[DEPTH-1] = valid[DEPTH-1] & out_ready.
  - For stage k < DEPTH-1: adv[k] = valid[k] & (~valid[k+1] | adv[k+1]).
  - Bubbles collapse: a stalled head does not stall younger stages while empty slots exist ahead of them.
- Handshakes:
  - in_ready = ~valid[0] | adv[0], purely from state and out_ready.
  - in_ready is independent of in_valid and flush_mask.
  - Accept occurs when in_valid & in_ready.
  - in_valid may assert while in_ready is low; the entry is held upstream and not captured.
- Stage k next state, normal:
  - Loads from stage k-1 (or input for k = 0) when the predecessor advances/accepts.
  - Else holds if valid and not advancing.
  - Else becomes invalid.
- Flush:
  - flush_mask[k]=1 forces valid[k]=0 at the edge, including an entry moving into k that same cycle.
  - Stage k's own entry still counts as leaving if adv[k]; the downstream stage receives it unless also flushed.
  - flush_mask[0] with an accept: in_ready stays asserted, the entry is accepted (handshake completes) and then discarded.
  - flush_mask[DEPTH-1] with out_valid & out_ready: the consumer still sees the transfer that cycle (outputs are registered state).
- Outputs: out_* reflect stage DEPTH-1 registers directly. No combinational path from in_* to out_*.
- Latency: an entry into an empty pipe with out_ready=1 appears at out_valid DEPTH cycles after acceptance. Throughput is 1 entry/cycle sustained.
- Hazard match (combinational): match_rsN[k] = valid[k] & regwrite[k] & (rd[k]==q_rsN) & (q_rsN != 0). x0 never matches. Matches reflect current state, before this cycle's flush.
- Occupancy: registered popcount of next-state valid bits, in 0..DEPTH.
- DEPTH=1: a single skid-free register; in_ready = ~valid | out_ready.

Test Plan:
- Reset, then stream 6 entries (payload 1..6, in_valid=1, out_ready=1), DEPTH=3 -> first out_valid 3 cycles after first accept; outputs 1..6 on consecutive cycles; in_ready constantly 1.
- Fill pipe with out_ready=0 -> after 3 accepts in_ready=0, occupancy=3. Raise out_ready for 1 cycle -> exactly one transfer, in_ready=1 that cycle, order preserved.
- Bubble collapse: head valid stalled, stage 0 valid, stage 1 empty -> next cycle stage 0 entry moves to stage 1 and in_ready=1.
- flush_mask=3'b011 while stage1 advances into stage2 and a new entry is accepted -> stage2 holds the old stage1 entry; stages 0-1 invalid; occupancy=1.
- Stage1 holds rd=5, regwrite=1; stage2 holds rd=5, regwrite=0; q_rs1=5, q_rs2=0 -> match_rs1=3'b010, match_rs2=3'b000. Even with rd=0 and regwrite=1 in a stage, q_rs=0 gives no match.
- Assert rst mid-stream with in_valid=1 -> next cycle all valid bits 0, occupancy=0, out_valid=0, in_ready=1; the entry offered during reset is not captured.
